// File: rtl/mesh_node_interface_if.sv
// mesh_node_interface_if: local-port bundle between one mesh node adapter and its source, sink and network port.
interface mesh_node_interface_if #(
  parameter int X_NODES = 2,
  parameter int Y_NODES = 2,
  parameter int DATA_W = 8,
  parameter int CNT_W = 32
);
  localparam int ADDR_W = (X_NODES * Y_NODES > 1) ? $clog2(X_NODES * Y_NODES) : 1;
  typedef struct packed {
    logic valid;
    logic [ADDR_W-1:0] source;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } packet_mesh;
  logic gen_valid;
  logic [ADDR_W-1:0] gen_dest;
  logic [DATA_W-1:0] gen_data;
  logic gen_ready;
  packet_mesh net_out;
  logic net_hold;
  packet_mesh net_in;
  logic node_hold;
  logic sink_valid;
  packet_mesh sink_pkt;
  logic sink_ready;
  logic [CNT_W-1:0] inj_count;
  logic [CNT_W-1:0] gen_drop_count;
  logic [CNT_W-1:0] rx_count;
  logic misroute_err;
  logic rx_overflow_err;
  modport master (
    output gen_valid, gen_dest, gen_data, net_hold, net_in, sink_ready,
    input gen_ready, net_out, node_hold, sink_valid, sink_pkt,
    input inj_count, gen_drop_count, rx_count, misroute_err, rx_overflow_err
  );
  modport slave (
    input gen_valid, gen_dest, gen_data, net_hold, net_in, sink_ready,
    output gen_ready, net_out, node_hold, sink_valid, sink_pkt,
    output inj_count, gen_drop_count, rx_count, misroute_err, rx_overflow_err
  );
endinterface

// File: rtl/mesh_node_interface.sv
// mesh_node_interface: buffers source packets into the mesh local port and ejected packets towards the sink.
module mesh_node_interface #(
  parameter int X_NODES = 2,
  parameter int Y_NODES = 2,
  parameter int NODE_ID = 0,
  parameter int INJ_DEPTH = 8,
  parameter int RX_DEPTH = 4,
  parameter int CNT_W = 32,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic reset,
  mesh_node_interface_if.slave bus
);
  localparam int ADDR_W = (X_NODES * Y_NODES > 1) ? $clog2(X_NODES * Y_NODES) : 1;
  localparam int PW = 2 * ADDR_W + DATA_W;
  localparam int IAW = $clog2(INJ_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [IAW:0] INJ_FULL = (IAW + 1)'(INJ_DEPTH);
  localparam logic [RAW:0] RX_FULL = (RAW + 1)'(RX_DEPTH);
  localparam logic [RAW:0] RX_HOLD = (RAW + 1)'(RX_DEPTH - 1);
  localparam logic [ADDR_W-1:0] MY_ID = ADDR_W'(NODE_ID);
  logic [PW-1:0] inj_mem_q [INJ_DEPTH];
  logic [PW-1:0] rx_mem_q [RX_DEPTH];
  logic [IAW-1:0] inj_wr_q, inj_wr_d, inj_rd_q, inj_rd_d;
  logic [IAW:0] inj_cnt_q, inj_cnt_d;
  logic [RAW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RAW:0] rx_cnt_q, rx_cnt_d;
  logic net_valid_q, net_valid_d;
  logic [PW-1:0] net_pkt_q, net_pkt_d;
  logic node_hold_q, node_hold_d;
  logic [CNT_W-1:0] inj_count_q, inj_count_d, drop_count_q, drop_count_d, rx_count_q, rx_count_d;
  logic misroute_q, misroute_d, rx_ovf_q, rx_ovf_d;
  logic inj_full, inj_push, inj_pop, rx_full, rx_push, rx_pop, sink_valid;
  always_comb begin
    inj_full = inj_cnt_q == INJ_FULL;
    inj_push = bus.gen_valid && !inj_full;
    inj_pop = (inj_cnt_q != '0) && !bus.net_hold;
    inj_wr_d = inj_wr_q + IAW'(inj_push);
    inj_rd_d = inj_rd_q + IAW'(inj_pop);
    inj_cnt_d = inj_cnt_q + (IAW + 1)'(inj_push) - (IAW + 1)'(inj_pop);
    net_valid_d = inj_pop;
    net_pkt_d = inj_pop ? inj_mem_q[inj_rd_q] : net_pkt_q;
    inj_count_d = inj_count_q + CNT_W'(inj_pop);
    drop_count_d = drop_count_q + CNT_W'(bus.gen_valid && inj_full);
    sink_valid = rx_cnt_q != '0;
    rx_full = rx_cnt_q == RX_FULL;
    rx_pop = sink_valid && bus.sink_ready;
    // a same-edge pop frees the slot first, so a full buffer can still accept
    rx_push = bus.net_in.valid && (!rx_full || rx_pop);
    rx_wr_d = rx_wr_q + RAW'(rx_push);
    rx_rd_d = rx_rd_q + RAW'(rx_pop);
    rx_cnt_d = rx_cnt_q + (RAW + 1)'(rx_push) - (RAW + 1)'(rx_pop);
    rx_count_d = rx_count_q + CNT_W'(rx_push);
    rx_ovf_d = rx_ovf_q || (bus.net_in.valid && !rx_push);
    misroute_d = misroute_q || (bus.net_in.valid && bus.net_in.dest != MY_ID);
    // keep one slot free for a packet the router may already have launched
    node_hold_d = rx_cnt_d >= RX_HOLD;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_wr_q <= '0;
      inj_rd_q <= '0;
      inj_cnt_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      rx_cnt_q <= '0;
      net_valid_q <= 1'b0;
      net_pkt_q <= '0;
      node_hold_q <= 1'b0;
      inj_count_q <= '0;
      drop_count_q <= '0;
      rx_count_q <= '0;
      misroute_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      inj_wr_q <= inj_wr_d;
      inj_rd_q <= inj_rd_d;
      inj_cnt_q <= inj_cnt_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      net_valid_q <= net_valid_d;
      net_pkt_q <= net_pkt_d;
      node_hold_q <= node_hold_d;
      inj_count_q <= inj_count_d;
      drop_count_q <= drop_count_d;
      rx_count_q <= rx_count_d;
      misroute_q <= misroute_d;
      rx_ovf_q <= rx_ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (inj_push) inj_mem_q[inj_wr_q] <= {MY_ID, bus.gen_dest, bus.gen_data};
    if (rx_push) rx_mem_q[rx_wr_q] <= bus.net_in[PW-1:0];
  end
  assign bus.gen_ready = !inj_full;
  assign bus.net_out = {net_valid_q, net_pkt_q};
  assign bus.node_hold = node_hold_q;
  assign bus.sink_valid = sink_valid;
  assign bus.sink_pkt = {sink_valid, rx_mem_q[rx_rd_q]};
  assign bus.inj_count = inj_count_q;
  assign bus.gen_drop_count = drop_count_q;
  assign bus.rx_count = rx_count_q;
  assign bus.misroute_err = misroute_q;
  assign bus.rx_overflow_err = rx_ovf_q;
endmodule

// File: tb/tb_mesh_node_interface.sv
// tb_mesh_node_interface: directed and random traffic against a queue-based model of the node adapter.
module tb_mesh_node_interface;
  localparam int NODE_ID = 1;
  localparam int INJ_DEPTH = 8;
  localparam int RX_DEPTH = 4;
  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dest;
    logic [7:0] data;
  } p_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  p_t inj_q[$];
  p_t rx_q[$];
  p_t m_net;
  logic m_valid, m_hold, m_mis, m_ovf;
  logic [31:0] m_inj, m_drop, m_rx;
  mesh_node_interface_if #(.X_NODES(2), .Y_NODES(2), .DATA_W(8), .CNT_W(32)) ifc ();
  mesh_node_interface #(
    .X_NODES(2), .Y_NODES(2), .NODE_ID(NODE_ID), .INJ_DEPTH(INJ_DEPTH),
    .RX_DEPTH(RX_DEPTH), .CNT_W(32), .DATA_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    inj_q.delete();
    rx_q.delete();
    m_net = '0;
    m_valid = 0;
    m_hold = 0;
    m_mis = 0;
    m_ovf = 0;
    m_inj = 0;
    m_drop = 0;
    m_rx = 0;
  endtask
  task automatic check_all();
    chk("gen_ready", ifc.gen_ready, inj_q.size() < INJ_DEPTH);
    chk("net_valid", ifc.net_out.valid, m_valid);
    chk("net_src", ifc.net_out.source, m_net.src);
    chk("net_dest", ifc.net_out.dest, m_net.dest);
    chk("net_data", ifc.net_out.data, m_net.data);
    chk("sink_valid", ifc.sink_valid, rx_q.size() > 0);
    if (rx_q.size() > 0) begin
      chk("sink_src", ifc.sink_pkt.source, rx_q[0].src);
      chk("sink_dest", ifc.sink_pkt.dest, rx_q[0].dest);
      chk("sink_data", ifc.sink_pkt.data, rx_q[0].data);
    end
    chk("node_hold", ifc.node_hold, m_hold);
    chk("inj_count", ifc.inj_count, m_inj);
    chk("drop_count", ifc.gen_drop_count, m_drop);
    chk("rx_count", ifc.rx_count, m_rx);
    chk("misroute", ifc.misroute_err, m_mis);
    chk("rx_ovf", ifc.rx_overflow_err, m_ovf);
  endtask
  task automatic step();
    bit full;
    full = inj_q.size() == INJ_DEPTH;
    m_valid = 0;
    if (inj_q.size() > 0 && !ifc.net_hold) begin
      m_net = inj_q.pop_front();
      m_valid = 1;
      m_inj++;
    end
    if (ifc.gen_valid) begin
      if (!full) inj_q.push_back('{src: 2'(NODE_ID), dest: ifc.gen_dest, data: ifc.gen_data});
      else m_drop++;
    end
    if (rx_q.size() > 0 && ifc.sink_ready) void'(rx_q.pop_front());
    if (ifc.net_in.valid) begin
      if (rx_q.size() < RX_DEPTH) begin
        rx_q.push_back('{src: ifc.net_in.source, dest: ifc.net_in.dest, data: ifc.net_in.data});
        m_rx++;
      end else m_ovf = 1;
      if (ifc.net_in.dest != 2'(NODE_ID)) m_mis = 1;
    end
    m_hold = rx_q.size() >= RX_DEPTH - 1;
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic gen(input logic v, input logic [1:0] d, input logic [7:0] x);
    ifc.gen_valid = v;
    ifc.gen_dest = d;
    ifc.gen_data = x;
  endtask
  task automatic deliver(input logic v, input logic [1:0] s, input logic [1:0] d, input logic [7:0] x);
    ifc.net_in.valid = v;
    ifc.net_in.source = s;
    ifc.net_in.dest = d;
    ifc.net_in.data = x;
  endtask
  initial begin
    gen(0, 0, 0);
    deliver(0, 0, 0, 0);
    ifc.net_hold = 0;
    ifc.sink_ready = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1;
    #1;
    check_all();
    // single packet: visible two edges after the push
    gen(1, 3, 8'hA5);
    step();
    gen(0, 0, 0);
    step();
    chk("single_valid", ifc.net_out.valid, 1);
    chk("single_dest", ifc.net_out.dest, 3);
    chk("single_src", ifc.net_out.source, NODE_ID);
    chk("single_data", ifc.net_out.data, 8'hA5);
    chk("single_inj", ifc.inj_count, 1);
    step();
    // hold back-pressure
    ifc.net_hold = 1;
    for (int i = 0; i < 3; i++) begin
      gen(1, 2'($urandom), 8'($urandom));
      step();
    end
    gen(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_quiet", ifc.net_out.valid, 0);
    end
    ifc.net_hold = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_burst", ifc.net_out.valid, 1);
    end
    step();
    chk("hold_inj", ifc.inj_count, 4);
    // injection FIFO full
    ifc.net_hold = 1;
    for (int i = 0; i < 10; i++) begin
      gen(1, 2'($urandom), 8'($urandom));
      step();
    end
    gen(0, 0, 0);
    chk("full_ready", ifc.gen_ready, 0);
    chk("full_drop", ifc.gen_drop_count, 2);
    ifc.net_hold = 0;
    for (int i = 0; i < 9; i++) step();
    // receive hold and overflow
    ifc.sink_ready = 0;
    for (int i = 0; i < 3; i++) begin
      deliver(1, 2'($urandom), 2'(NODE_ID), 8'($urandom));
      step();
    end
    chk("rx_hold", ifc.node_hold, 1);
    for (int i = 0; i < 2; i++) begin
      deliver(1, 2'($urandom), 2'(NODE_ID), 8'($urandom));
      step();
    end
    deliver(0, 0, 0, 0);
    step();
    chk("rx_ovf_set", ifc.rx_overflow_err, 1);
    chk("rx_count4", ifc.rx_count, 4);
    chk("rx_mis_clean", ifc.misroute_err, 0);
    ifc.sink_ready = 1;
    for (int i = 0; i < 5; i++) step();
    // misrouted packet is still buffered
    ifc.sink_ready = 0;
    deliver(1, 0, 2'(NODE_ID + 1), 8'h3C);
    step();
    deliver(0, 0, 0, 0);
    chk("mis_flag", ifc.misroute_err, 1);
    chk("mis_sink", ifc.sink_valid, 1);
    chk("mis_data", ifc.sink_pkt.data, 8'h3C);
    chk("mis_dest", ifc.sink_pkt.dest, NODE_ID + 1);
    ifc.sink_ready = 1;
    step();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      gen(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom));
      ifc.net_hold = ($urandom_range(0, 3) == 0);
      deliver(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 8'($urandom));
      ifc.sink_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    // asynchronous reset with both FIFOs partially occupied
    ifc.net_hold = 1;
    ifc.sink_ready = 0;
    for (int i = 0; i < 3; i++) begin
      gen(1, 2'($urandom), 8'($urandom));
      deliver(1, 2'($urandom), 2'(NODE_ID), 8'($urandom));
      step();
    end
    gen(0, 0, 0);
    deliver(0, 0, 0, 0);
    ifc.net_hold = 0;
    step();
    #3;
    reset = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1;
    gen(1, 2, 8'h5A);
    step();
    gen(0, 0, 0);
    step();
    chk("post_valid", ifc.net_out.valid, 1);
    chk("post_data", ifc.net_out.data, 8'h5A);
    chk("post_inj", ifc.inj_count, 1);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
